// File: rtl/bsc_ibus_arb_if.sv
// ---------------------------------------------------------------------------
// bsc_ibus_arb_if
//   Signal bundle between the three IBUS masters (M0 = DMAC, M1 = CPU data,
//   M2 = CPU fetch), the arbiter, and the BSC IBUS slave port.
//
//   Master-side fields are packed {M2,M1,M0}:
//     M_A / M_DI   96  address / write data, 32 bits per master
//     M_BA         12  byte enables, 4 bits per master
//     M_WE/REQ/LOCK 3  per-master write strobe / request / bus lock
//     M_BUSY        3  per-master stall (from arbiter)
//     M_DO         32  read data broadcast to all masters (from arbiter)
//     GNT           2  current owner index, 3 = none (from arbiter)
//   BSC-side fields:
//     IBUS_A/DI/BA/WE/REQ/LOCK  muxed request towards the BSC (from arbiter)
//     IBUS_DO / IBUS_BUSY       read data and stall from the BSC
//
//   modport slave  : arbiter view (serves the masters, drives IBUS)
//   modport master : environment view (masters plus the BSC)
// ---------------------------------------------------------------------------
interface bsc_ibus_arb_if;
   logic [95:0] M_A;
   logic [95:0] M_DI;
   logic [11:0] M_BA;
   logic [2:0]  M_WE;
   logic [2:0]  M_REQ;
   logic [2:0]  M_LOCK;
   logic [2:0]  M_BUSY;
   logic [31:0] M_DO;
   logic [1:0]  GNT;
   logic [31:0] IBUS_A;
   logic [31:0] IBUS_DI;
   logic [3:0]  IBUS_BA;
   logic        IBUS_WE;
   logic        IBUS_REQ;
   logic        IBUS_LOCK;
   logic [31:0] IBUS_DO;
   logic        IBUS_BUSY;

   modport slave (
      input  M_A, M_DI, M_BA, M_WE, M_REQ, M_LOCK, IBUS_DO, IBUS_BUSY,
      output M_BUSY, M_DO, GNT, IBUS_A, IBUS_DI, IBUS_BA, IBUS_WE,
             IBUS_REQ, IBUS_LOCK
   );

   modport master (
      output M_A, M_DI, M_BA, M_WE, M_REQ, M_LOCK, IBUS_DO, IBUS_BUSY,
      input  M_BUSY, M_DO, GNT, IBUS_A, IBUS_DI, IBUS_BA, IBUS_WE,
             IBUS_REQ, IBUS_LOCK
   );
endinterface

// File: rtl/bsc_ibus_arb.sv
// ---------------------------------------------------------------------------
// bsc_ibus_arb
//   Shares the single BSC IBUS slave port between three masters. One master
//   owns the bus at a time; its address/data/byte-enable/write fields are
//   muxed onto IBUS. Locked (read-modify-write) sequences keep ownership
//   between accesses, with an optional watchdog that releases a lock held
//   with no pending request for LOCK_MAX CE_R cycles.
//
//   Parameters:
//     RR       0 = fixed priority M0>M1>M2, 1 = round-robin
//     LOCK_MAX idle-lock watchdog length in CE_R cycles, 0 = disabled
//
//   Ports:
//     CLK   system clock
//     RST   synchronous active-high reset (independent of CE_R)
//     CE_R  rising-phase clock enable gating every state update
//     bus   master/IBUS bundle, arbiter (slave) view
// ---------------------------------------------------------------------------
module bsc_ibus_arb #(
   parameter int RR       = 0,
   parameter int LOCK_MAX = 16
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          CE_R,
   bsc_ibus_arb_if.slave bus
);

   localparam int NM  = 3;
   localparam int LCW = (LOCK_MAX > 0) ? $clog2(LOCK_MAX + 1) : 1;
   localparam logic [LCW-1:0] LOCK_LAST = (LOCK_MAX > 0) ? LCW'(LOCK_MAX - 1) : '0;
   localparam logic [1:0]     NO_OWNER  = 2'd3;

   typedef enum logic [1:0] {
      ST_ARB  = 2'd0,
      ST_OWN  = 2'd1,
      ST_LOCK = 2'd2
   } state_t;

   state_t           r_state;
   logic [1:0]       r_owner;
   logic [1:0]       r_rr_ptr;
   logic [LCW-1:0]   r_lock_cnt;

   // per-master views of the packed master buses
   logic [NM-1:0][31:0] w_m_a;
   logic [NM-1:0][31:0] w_m_di;
   logic [NM-1:0][3:0]  w_m_ba;

   logic       w_owned;
   logic [1:0] w_oi;
   logic       w_req_o;
   logic       w_lock_o;
   logic       w_any;
   logic [1:0] w_win;
   logic [1:0] w_next_ptr;
   logic       w_wd_fire;
   logic [NM-1:0] w_busy;

   assign w_m_a  = bus.M_A;
   assign w_m_di = bus.M_DI;
   assign w_m_ba = bus.M_BA;

   // Index into the scan order starting at base, wrapping modulo 3.
   function automatic logic [1:0] scan_idx(input logic [1:0] base, input int k);
      logic [2:0] s;
      s = {1'b0, base} + 3'(k);
      return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
   endfunction

   assign w_owned = (r_state != ST_ARB);
   // r_owner is only 3 while in ARB, where the muxed fields are forced to 0;
   // clamp it so the mux index always stays inside the three masters.
   assign w_oi     = (r_owner == NO_OWNER) ? 2'd0 : r_owner;
   assign w_req_o  = bus.M_REQ[w_oi];
   assign w_lock_o = bus.M_LOCK[w_oi];
   assign w_any    = |bus.M_REQ;

   assign w_next_ptr = (w_oi == 2'd2) ? 2'd0 : w_oi + 2'd1;
   assign w_wd_fire  = (LOCK_MAX != 0) && (r_lock_cnt == LOCK_LAST);

   // Winner: scan three slots from a base. Fixed priority is a round-robin
   // scan whose base never moves off M0, so both modes share one scanner.
   always_comb begin
      logic [1:0] base;
      logic [1:0] idx;
      base  = (RR != 0) ? r_rr_ptr : 2'd0;
      w_win = NO_OWNER;
      // descending so the earliest slot in scan order is the last to write
      for (int k = NM - 1; k >= 0; k--) begin
         idx = scan_idx(base, k);
         if (bus.M_REQ[idx]) w_win = idx;
      end
   end

   // Output mux: nothing reaches IBUS while arbitrating.
   assign bus.GNT       = r_owner;
   assign bus.M_DO      = bus.IBUS_DO;
   assign bus.IBUS_A    = w_owned ? w_m_a[w_oi]      : 32'd0;
   assign bus.IBUS_DI   = w_owned ? w_m_di[w_oi]     : 32'd0;
   assign bus.IBUS_BA   = w_owned ? w_m_ba[w_oi]     : 4'd0;
   assign bus.IBUS_WE   = w_owned ? bus.M_WE[w_oi]   : 1'b0;
   assign bus.IBUS_REQ  = w_owned ? w_req_o          : 1'b0;
   assign bus.IBUS_LOCK = w_owned ? w_lock_o         : 1'b0;

   // A requester is released only in the cycle it owns the bus and the BSC
   // reports the access finished; everyone else stays stalled.
   for (genvar i = 0; i < NM; i++) begin : g_busy
      assign w_busy[i] = bus.M_REQ[i] &
                         ~(w_owned & (r_owner == 2'(i)) & ~bus.IBUS_BUSY);
   end
   assign bus.M_BUSY = w_busy;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= ST_ARB;
         r_owner    <= NO_OWNER;
         r_rr_ptr   <= 2'd0;
         r_lock_cnt <= '0;
      end else if (CE_R) begin
         case (r_state)
            ST_ARB: begin
               if (w_any) begin
                  r_owner    <= w_win;
                  r_state    <= ST_OWN;
                  r_lock_cnt <= '0;
               end
            end

            ST_OWN: begin
               if (!w_req_o) begin
                  // owner withdrew (also covers REQ dropping on the
                  // completion cycle): give the bus back
                  r_state <= ST_ARB;
                  r_owner <= NO_OWNER;
               end else if (!bus.IBUS_BUSY) begin
                  r_rr_ptr <= w_next_ptr;
                  if (w_lock_o) begin
                     r_state    <= ST_LOCK;
                     r_lock_cnt <= '0;
                  end else begin
                     r_state <= ST_ARB;
                     r_owner <= NO_OWNER;
                  end
               end
            end

            ST_LOCK: begin
               if (!w_req_o && !w_lock_o) begin
                  r_state <= ST_ARB;
                  r_owner <= NO_OWNER;
               end else if (w_req_o) begin
                  // an access inside the locked sequence restarts the
                  // idle watchdog
                  r_lock_cnt <= '0;
                  if (!bus.IBUS_BUSY) begin
                     r_rr_ptr <= w_next_ptr;
                     if (!w_lock_o) begin
                        r_state <= ST_ARB;
                        r_owner <= NO_OWNER;
                     end
                  end
               end else begin
                  // lock held with nothing pending: count toward release
                  r_lock_cnt <= r_lock_cnt + LCW'(1);
                  if (w_wd_fire) begin
                     r_state <= ST_ARB;
                     r_owner <= NO_OWNER;
                  end
               end
            end

            default: begin
               r_state <= ST_ARB;
               r_owner <= NO_OWNER;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bsc_ibus_arb.sv
module tb_bsc_ibus_arb;
   localparam logic [31:0] A0 = 32'h1000_0000, A1 = 32'h0600_0004, A2 = 32'h2000_0008;
   localparam logic [31:0] D0 = 32'hD0D0_0000, D1 = 32'hD1D1_1111, D2 = 32'hD2D2_2222;

   typedef struct packed {
      logic [1:0]  gnt;
      logic [31:0] a;
      logic        we;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        CE_R = 1'b1;
   logic [2:0]  m_req = '0, m_lock = '0, m_we = '0;
   logic [95:0] m_a  = {A2, A1, A0};
   logic [95:0] m_di = {D2, D1, D0};
   logic [11:0] m_ba = {4'h3, 4'hF, 4'h1};
   logic [31:0] ibus_do = 32'h0;
   int          lat = 0, cnt0 = 0, cnt1 = 0;
   int          n_chk = 0, n_fail = 0;
   exp_t        q0[$], q1[$];
   bit          prev_done[2];

   always #5 CLK = ~CLK;

   bsc_ibus_arb_if bus0 ();
   bsc_ibus_arb_if bus1 ();

   assign bus0.M_A = m_a;   assign bus1.M_A = m_a;
   assign bus0.M_DI = m_di; assign bus1.M_DI = m_di;
   assign bus0.M_BA = m_ba; assign bus1.M_BA = m_ba;
   assign bus0.M_WE = m_we; assign bus1.M_WE = m_we;
   assign bus0.M_REQ = m_req;   assign bus1.M_REQ = m_req;
   assign bus0.M_LOCK = m_lock; assign bus1.M_LOCK = m_lock;
   assign bus0.IBUS_DO = ibus_do; assign bus1.IBUS_DO = ibus_do;
   // BSC model: BUSY high from the first request cycle for `lat` cycles
   assign bus0.IBUS_BUSY = bus0.IBUS_REQ && (cnt0 < lat);
   assign bus1.IBUS_BUSY = bus1.IBUS_REQ && (cnt1 < lat);

   always @(posedge CLK) begin
      if (RST || !bus0.IBUS_REQ || !bus0.IBUS_BUSY) cnt0 <= 0;
      else if (CE_R) cnt0 <= cnt0 + 1;
      if (RST || !bus1.IBUS_REQ || !bus1.IBUS_BUSY) cnt1 <= 0;
      else if (CE_R) cnt1 <= cnt1 + 1;
   end

   bsc_ibus_arb #(.RR(0), .LOCK_MAX(4)) u_dut0 (.CLK(CLK), .RST(RST), .CE_R(CE_R), .bus(bus0.slave));
   bsc_ibus_arb #(.RR(1), .LOCK_MAX(4)) u_dut1 (.CLK(CLK), .RST(RST), .CE_R(CE_R), .bus(bus1.slave));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk2(input string name, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] exp);
      chk({name, "/fixed"}, a0, exp);
      chk({name, "/rr"}, a1, exp);
   endtask

   function automatic exp_t mk(input int m, input bit we);
      exp_t e;
      e.gnt = 2'(m);
      e.a   = m_a[m*32 +: 32];
      e.we  = we;
      return e;
   endfunction

   task automatic push(input int m, input bit we);
      q0.push_back(mk(m, we));
      q1.push_back(mk(m, we));
   endtask

   task automatic start(input int m, input bit we, input bit lock);
      m_req[m] = 1'b1; m_we[m] = we; m_lock[m] = lock;
      push(m, we);
   endtask

   // wait for master m's completion cycle, then drop its request after the edge
   task automatic finish(input int m, input bit keep_lock, output int waited);
      bit ok = 0;
      waited = -1;
      for (int c = 0; c < 60; c++) begin
         @(negedge CLK);
         if (bus0.M_REQ[m] && !bus0.M_BUSY[m]) begin ok = 1; waited = c + 1; break; end
      end
      chk($sformatf("done_m%0d", m), 32'(ok), 32'd1);
      @(posedge CLK); #1;
      m_req[m] = 1'b0; m_we[m] = 1'b0;
      if (!keep_lock) m_lock[m] = 1'b0;
   endtask

   // scoreboard monitor: every completion cycle pops one expected grant
   task automatic mon(input int d, input logic [1:0] gnt, input logic ireq, input logic ibusy,
                      input logic ilock, input logic [31:0] ia, input logic iwe,
                      input logic [2:0] mbusy, input logic [31:0] mdo);
      exp_t e;
      if (prev_done[d]) chk($sformatf("arb_gap_d%0d", d), 32'(gnt), 32'd3);
      prev_done[d] = 1'b0;
      if (!RST && CE_R && gnt != 2'd3 && ireq && !ibusy) begin
         if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_done_d%0d: got gnt %0d addr %h expected no completion", d, gnt, ia);
         end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("sb_gnt_d%0d", d), 32'(gnt), 32'(e.gnt));
            chk($sformatf("sb_addr_d%0d", d), ia, e.a);
            chk($sformatf("sb_we_d%0d", d), 32'(iwe), 32'(e.we));
            chk($sformatf("sb_mbusy_d%0d", d), 32'(mbusy), 32'(m_req & ~(3'b001 << e.gnt)));
            chk($sformatf("sb_mdo_d%0d", d), mdo, ibus_do);
         end
         prev_done[d] = !ilock;
      end
   endtask

   always @(negedge CLK) begin
      mon(0, bus0.GNT, bus0.IBUS_REQ, bus0.IBUS_BUSY, bus0.IBUS_LOCK, bus0.IBUS_A,
          bus0.IBUS_WE, bus0.M_BUSY, bus0.M_DO);
      mon(1, bus1.GNT, bus1.IBUS_REQ, bus1.IBUS_BUSY, bus1.IBUS_LOCK, bus1.IBUS_A,
          bus1.IBUS_WE, bus1.M_BUSY, bus1.M_DO);
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no end of test expected end before 500000");
      $fatal(1);
   end

   initial begin
      int  w;
      bit  ok;
      ibus_do = 32'hCAFE_0001;

      // reset with requests pending: nothing granted, every requester stalled
      m_req = 3'b101;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk2("rst_gnt", 32'(bus0.GNT), 32'(bus1.GNT), 32'd3);
      chk2("rst_ireq", 32'(bus0.IBUS_REQ), 32'(bus1.IBUS_REQ), 32'd0);
      chk2("rst_ia", bus0.IBUS_A, bus1.IBUS_A, 32'd0);
      chk2("rst_mbusy", 32'(bus0.M_BUSY), 32'(bus1.M_BUSY), 32'b101);
      @(posedge CLK); #1;
      RST = 1'b0; m_req = '0;

      // M1 single read, BSC busy for 3 cycles
      lat = 3;
      start(1, 1'b0, 1'b0);
      @(negedge CLK);
      chk2("t1_arb_gnt", 32'(bus0.GNT), 32'(bus1.GNT), 32'd3);
      chk2("t1_arb_ireq", 32'(bus0.IBUS_REQ), 32'(bus1.IBUS_REQ), 32'd0);
      @(negedge CLK);
      chk2("t1_gnt", 32'(bus0.GNT), 32'(bus1.GNT), 32'd1);
      chk2("t1_ia", bus0.IBUS_A, bus1.IBUS_A, 32'h0600_0004);
      chk2("t1_idi", bus0.IBUS_DI, bus1.IBUS_DI, D1);
      chk2("t1_iba", 32'(bus0.IBUS_BA), 32'(bus1.IBUS_BA), 32'hF);
      chk2("t1_ireq", 32'(bus0.IBUS_REQ), 32'(bus1.IBUS_REQ), 32'd1);
      chk2("t1_mbusy", 32'(bus0.M_BUSY), 32'(bus1.M_BUSY), 32'b010);
      chk2("t1_mdo", bus0.M_DO, bus1.M_DO, 32'hCAFE_0001);
      finish(1, 1'b0, w);
      chk("t1_latency", 32'(w), 32'd3);

      // CE_R low: state frozen, stall output still follows REQ
      lat = 1;
      CE_R = 1'b0;
      start(2, 1'b0, 1'b0);
      repeat (3) begin
         @(negedge CLK);
         chk2("frz_gnt", 32'(bus0.GNT), 32'(bus1.GNT), 32'd3);
         chk2("frz_mbusy", 32'(bus0.M_BUSY), 32'(bus1.M_BUSY), 32'b100);
      end
      @(posedge CLK); #1;
      CE_R = 1'b1;
      finish(2, 1'b0, w);

      // all three request continuously: fixed 0,0,0.. vs round-robin 0,1,2,..
      lat = 0;
      ibus_do = 32'h5A5A_0002;
      for (int i = 0; i < 6; i++) begin
         q0.push_back(mk(0, 1'b0));
         q1.push_back(mk(i % 3, 1'b0));
      end
      m_req = 3'b111;
      ok = 0;
      for (int c = 0; c < 60; c++) begin
         @(posedge CLK);
         if (q0.size() == 0 && q1.size() == 0) begin ok = 1; break; end
      end
      chk("t2_drain", 32'(ok), 32'd1);
      #1;
      m_req = '0;

      // M1 locked read / idle / write; M0 arrives mid-sequence and waits
      lat = 1;
      start(1, 1'b0, 1'b1);
      finish(1, 1'b1, w);
      m_req[0] = 1'b1;
      repeat (2) begin
         @(negedge CLK);
         chk2("lk_gnt", 32'(bus0.GNT), 32'(bus1.GNT), 32'd1);
         chk2("lk_ilock", 32'(bus0.IBUS_LOCK), 32'(bus1.IBUS_LOCK), 32'd1);
         chk2("lk_mbusy", 32'(bus0.M_BUSY), 32'(bus1.M_BUSY), 32'b001);
         @(posedge CLK);
      end
      #1;
      start(1, 1'b1, 1'b1);
      push(0, 1'b0);
      @(negedge CLK);
      chk2("lk_wr_ilock", 32'(bus0.IBUS_LOCK), 32'(bus1.IBUS_LOCK), 32'd1);
      chk2("lk_wr_iwe", 32'(bus0.IBUS_WE), 32'(bus1.IBUS_WE), 32'd1);
      finish(1, 1'b0, w);
      finish(0, 1'b0, w);

      // watchdog: M2 keeps LOCK with no request, forced release after 4 cycles
      start(2, 1'b0, 1'b1);
      finish(2, 1'b1, w);
      m_req[0] = 1'b1;
      push(0, 1'b0);
      repeat (4) begin
         @(negedge CLK);
         chk2("wd_gnt", 32'(bus0.GNT), 32'(bus1.GNT), 32'd2);
         chk2("wd_ilock", 32'(bus0.IBUS_LOCK), 32'(bus1.IBUS_LOCK), 32'd1);
         chk2("wd_mbusy", 32'(bus0.M_BUSY), 32'(bus1.M_BUSY), 32'b001);
      end
      @(negedge CLK);
      chk2("wd_release", 32'(bus0.GNT), 32'(bus1.GNT), 32'd3);
      @(negedge CLK);
      chk2("wd_next", 32'(bus0.GNT), 32'(bus1.GNT), 32'd0);
      finish(0, 1'b0, w);
      m_lock[2] = 1'b0;

      // reset during a busy M1 transfer; rearbitration restarts at M0
      lat = 5;
      m_req[1] = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      chk2("rs_gnt", 32'(bus0.GNT), 32'(bus1.GNT), 32'd1);
      chk2("rs_ibusy", 32'(bus0.IBUS_BUSY), 32'(bus1.IBUS_BUSY), 32'd1);
      @(posedge CLK); #1;
      RST = 1'b1; m_req[0] = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0; lat = 1;
      @(negedge CLK);
      chk2("rs_after_gnt", 32'(bus0.GNT), 32'(bus1.GNT), 32'd3);
      chk2("rs_after_ireq", 32'(bus0.IBUS_REQ), 32'(bus1.IBUS_REQ), 32'd0);
      chk2("rs_after_mbusy", 32'(bus0.M_BUSY), 32'(bus1.M_BUSY), 32'b011);
      push(0, 1'b0);
      push(1, 1'b0);
      finish(0, 1'b0, w);
      finish(1, 1'b0, w);

      repeat (3) @(negedge CLK);
      chk("q_fixed_empty", 32'(q0.size()), 32'd0);
      chk("q_rr_empty", 32'(q1.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/bsc_ibus_arb.md
Name: bsc_ibus_arb

Overview:
- Arbiter and sequencer for the internal bus (IBUS) slave port of the bus state controller.
- Shares that single port between three masters: M0 = DMAC, M1 = CPU data access, M2 = CPU instruction fetch.
- Grants one master at a time and muxes its address, data, byte-enable and write signals onto IBUS.
- Honours locked (read-modify-write) sequences, with an optional watchdog that forces a stuck lock to release.

Parameters:
- RR, 0: 0 = fixed priority M0>M1>M2; 1 = round-robin.
- LOCK_MAX, 16: maximum number of CE_R cycles a master may hold LOCK state with no pending request; 0 disables the watchdog.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- CE_R  in  1  rising-phase clock enable; all state updates are gated by it
- M_A  in  96  master addresses {M2,M1,M0}, 32 bits each
- M_DI  in  96  master write data {M2,M1,M0}
- M_BA  in  12  master byte enables, 4 bits each
- M_WE  in  3  per-master write strobe
- M_REQ  in  3  per-master access request; held until BUSY drops
- M_LOCK  in  3  per-master bus lock request
- M_BUSY  out  3  per-master stall
- M_DO  out  32  read data, passed through from IBUS_DO to every master
- GNT  out  2  current owner index; 3 = no owner
- IBUS_A  out  32  muxed address
- IBUS_DI  out  32  muxed write data
- IBUS_BA  out  4  muxed byte enables
- IBUS_WE  out  1  muxed write strobe
- IBUS_REQ  out  1  request to the BSC
- IBUS_LOCK  out  1  lock to the BSC; inhibits bus release
- IBUS_DO  in  32  read data from the BSC
- IBUS_BUSY  in  1  BSC stall; the slave holds it high from the first request cycle until data/ack is valid

Behaviour:
- Registered state: STATE ∈ {ARB, OWN, LOCK}, OWNER[1:0], RR_PTR[1:0] (0..2), LOCK_CNT (width ≥ clog2(LOCK_MAX+1)).
- RST (sampled at a CLK edge, independent of CE_R) sets STATE=ARB, OWNER=3, RR_PTR=0, LOCK_CNT=0.
- Output values after reset:
  - GNT=3; IBUS_A, IBUS_DI, IBUS_BA, IBUS_WE, IBUS_REQ and IBUS_LOCK all 0.
  - M_BUSY = M_REQ, so every requester stalls.
- Reset mid-transfer abandons the transfer. No IBUS_REQ is driven in the cycle after reset.
- Output mux:
  - STATE=ARB: all IBUS_* outputs are 0.
  - Otherwise: IBUS_A/DI/BA/WE carry the owner's fields, IBUS_REQ = M_REQ[OWNER] and IBUS_LOCK = M_LOCK[OWNER].
  - M_DO = IBUS_DO at all times.
- M_BUSY[i] = M_REQ[i] & ~(STATE≠ARB & OWNER==i & ~IBUS_BUSY). A master completes in the cycle its BUSY is low while REQ is high.
- Winner selection:
  - RR=0: lowest index with M_REQ set.
  - RR=1: first requester found scanning RR_PTR, RR_PTR+1, RR_PTR+2 (mod 3).
- ARB state, on CE_R:
  - If any M_REQ is set: OWNER=winner, STATE=OWN, LOCK_CNT=0.
  - Else: hold.
  - Arbitration latency: minimum one CE_R cycle from REQ to IBUS_REQ.
- OWN state, on CE_R (conditions checked in order):
  - M_REQ[OWNER]=0: abandon; STATE=ARB, OWNER=3.
  - IBUS_BUSY=0 (completion) with M_LOCK[OWNER]=1: STATE=LOCK, LOCK_CNT=0.
  - IBUS_BUSY=0 (completion) with M_LOCK[OWNER]=0: STATE=ARB.
  - Every completion sets RR_PTR=(OWNER+1) mod 3.
  - Otherwise (busy): hold.
  - Back-to-back completions by different masters therefore have one ARB cycle between them.
- LOCK state, on CE_R:
  - M_LOCK[OWNER]=0 and M_REQ[OWNER]=0: STATE=ARB.
  - M_REQ[OWNER]=1: LOCK_CNT=0. On completion, STATE stays LOCK if M_LOCK=1, else goes to ARB.
  - M_REQ[OWNER]=0 and M_LOCK=1: LOCK_CNT++. If LOCK_MAX≠0 and LOCK_CNT==LOCK_MAX-1, force STATE=ARB.
  - Other masters stay stalled throughout LOCK.
- Simultaneous events:
  - Owner deasserts REQ in the same cycle IBUS_BUSY drops: treated as completion. REQ was high on the prior cycle, but the check uses current REQ, so the result is abandon → ARB, which is harmless.
  - A new request arriving during OWN waits; it never pre-empts the owner.
- CE_R=0: state frozen; combinational outputs still track inputs.

Test Plan:
- Reset, then M1 REQ (read, A=0x0600_0004) with IBUS_BUSY low after 3 cycles → GNT=1 one CE_R later, IBUS_A=0x0600_0004, M_BUSY[1] low exactly on the completion cycle, M_DO=IBUS_DO.
- RR=0; M0, M1 and M2 all request continuously → grant order 0,0,0…; M2 never granted while M0 requests; an ARB cycle separates each grant.
- RR=1; all three request continuously → grant order 0,1,2,0,1,2 with RR_PTR tracking owner+1.
- M1 locked RMW: read with LOCK=1, idle 2 cycles, then write → M0 request raised mid-sequence stays stalled until the write completes and LOCK drops; IBUS_LOCK high throughout.
- LOCK_MAX=4; M2 completes with LOCK=1, then holds LOCK with REQ low → forced ARB after 4 CE_R cycles; pending M0 granted the next cycle.
- RST asserted while OWN with IBUS_BUSY high → next cycle GNT=3, IBUS_REQ=0, M_BUSY=M_REQ; re-arbitration starts from RR_PTR=0.
